word_serializer: RTL
====================

# word_serializer

Parallel-to-serial front end for the sequence detectors. It accepts a WIDTH-bit word over a valid/ready handshake and drives it onto the single-bit `W` stream, one bit per `pCLK` cycle, either MSB-first or LSB-first. Between words it holds `W` at a programmable idle level. It sits directly upstream of the detector's `W` input.

## Interface
Parameters:
- `WIDTH`, 8: word length in bits; legal range is 2..32.
- `LSB_FIRST`, 0: 0 sends the MSB first; 1 sends the LSB first.
- `IDLE_BIT`, 1'b1: level driven on `W` while no word is being sent.

Ports:
- `pCLK` input 1: system clock; all state changes on the rising edge.
- `pREST` input 1: reset. One clock; reset is synchronous and active-high.
- `inWord` input WIDTH: parallel word; sampled only on an accept edge.
- `inValid` input 1: `inWord` is valid.
- `inReady` output 1: block can accept a word this cycle.
- `W` output 1: serial bit to the detector; registered.
- `wValid` output 1: `W` carries a data bit, not idle fill; registered.
- `wordDone` output 1: high during the cycle the last bit of a word is on `W`.
- `busy` output 1: high in state SHIFT.

## Operation
- FSM states:
  - IDLE (reset state).
  - SHIFT: a word is being sent.
- Accept: `inValid && inReady` sampled at a rising edge.
- IDLE, accept → SHIFT:
  - Load the shift register with `inWord`.
  - Set `bitCnt` to 0.
  - Drive `W` with the first bit: `inWord[WIDTH-1]`, or `inWord[0]` if `LSB_FIRST`.
  - Set `wValid` to 1.
- IDLE, no accept: stay in IDLE. `W = IDLE_BIT`, `wValid = 0`.
- SHIFT, `bitCnt < WIDTH-1`: shift by one toward the output end, `W` takes the next bit, `bitCnt` increments by 1.
- SHIFT, `bitCnt == WIDTH-1` (last bit on `W`):
  - `wordDone = 1` and `inReady = 1`.
  - With an accept: reload and stay in SHIFT. This is back-to-back operation with zero idle cycles between words.
  - Without an accept: go to IDLE. `W = IDLE_BIT` and `wValid = 0` on the next cycle.
- `inReady` is combinational: `!pREST && (state==IDLE || bitCnt==WIDTH-1)`.
- `inReady` is 0 in SHIFT while `bitCnt < WIDTH-1`. During those cycles `inWord` and `inValid` are ignored.
- `bitCnt` width is `$clog2(WIDTH)`. It never exceeds WIDTH-1 and wraps to 0 only on a reload.
- Reset (`pREST` high at an edge):
  - Outputs after the edge: state IDLE, `W = IDLE_BIT`, `wValid = 0`, `wordDone = 0`, `busy = 0`, `bitCnt = 0`, shift register 0.
  - Any word in flight is discarded with no partial completion.
  - `inReady` is 0 while `pREST` is high, so no accept can happen in a reset cycle.
- Simultaneous reset and accept: reset wins and the word is not taken.

## Timing
- Latency: a word accepted at edge k has its first bit on `W` after edge k, and its last bit after edge k+WIDTH-1.
- A word occupies exactly WIDTH consecutive cycles of `wValid = 1`.
- Sustained throughput is one word per WIDTH cycles when `inValid` is held high.
- `W` and `wValid` are direct flop outputs with no combinational path from the inputs.
- `wordDone` and `busy` are decoded from registered state only.
- `inReady` depends only on state and `pREST`, never on `inValid`.

## Structure
- Shared package `fsm_pkg` holds:
  - State encodings `S_IDLE = 1'b0` and `S_SHIFT = 1'b1`.
  - Any future serializer or detector state constants, so upstream and downstream stages agree.
- Sub-module `bit_counter_sync #(N)`:
  - Synchronous active-high clear, load-to-zero, increment, and `atMax` flag.
  - Kept separate so it can be reused by a matching downstream deserializer.
- Shift register and FSM live in `word_serializer`.
- The existing async-low-reset register primitives are not used, because the reset style differs.

## Test plan
- Reset then idle, WIDTH=8, IDLE_BIT=1: hold `pREST` for 2 cycles, release, no `inValid` for 10 cycles → `W = 1`, `wValid = 0`, `inReady = 1` throughout.
- Single word MSB-first: accept `8'hF0` → `W` = 1,1,1,1,0,0,0,0 on the 8 cycles after the accept edge; `wordDone` high only on the 8th; then `W` returns to 1.
- LSB-first: `LSB_FIRST=1`, accept `8'h0F` → `W` = 1,1,1,1,0,0,0,0; the output stream is identical to the MSB-first `8'hF0` case.
- Back-to-back: `inValid` held high with `8'hAA` then `8'h00` → 16 consecutive `wValid` cycles, `W` = 1,0,1,0,1,0,1,0, then 0 ×8, with no idle gap.
- Backpressure: drive `inValid` with `8'h55` at bitCnt=3 of a word in progress → `inReady = 0`, the word is not taken until the last-bit cycle, and the output is uncorrupted.
- Reset mid-word: assert `pREST` at bitCnt=4 → on the next cycle `W = IDLE_BIT`, `wValid = 0`, `wordDone` never pulses, and a fresh accept afterwards sends the full 8 bits.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared state encodings and limits for the serializer and its downstream detectors.
package fsm_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  localparam int unsigned SER_WIDTH_MIN = 32'd2;
  localparam int unsigned SER_WIDTH_MAX = 32'd32;

endpackage

// File: rtl/bit_counter_sync.sv
// Saturating bit-position counter with synchronous clear, reload-to-zero and terminal flag.
module bit_counter_sync #(
  parameter int N = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 load_zero,
  input  logic                 inc,
  output logic [$clog2(N)-1:0] count,
  output logic                 at_max
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] MAX_CNT = CW'(N - 1);

  logic [CW-1:0] count_r;

  // Counter register: clear and reload both force zero; increment stops at N-1.
  always_ff @(posedge clk) begin
    if (clr || load_zero) begin
      count_r <= {CW{1'b0}};
    end else if (inc && (count_r != MAX_CNT)) begin
      count_r <= count_r + 1'b1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count  = count_r;
  assign at_max = (count_r == MAX_CNT);

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial front end: takes a word over valid/ready and emits it one bit per
// clock on W, holding W at IDLE_BIT between words.
module word_serializer
  import fsm_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b0,
  parameter bit IDLE_BIT  = 1'b1
) (
  input  logic             pCLK,
  input  logic             pREST,
  input  logic [WIDTH-1:0] inWord,
  input  logic             inValid,
  output logic             inReady,
  output logic             W,
  output logic             wValid,
  output logic             wordDone,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic             w_r;
  logic             wvalid_r;
  logic [CW-1:0]    bit_cnt_s;
  logic             at_max_s;
  logic             accept_s;
  logic             inc_s;

  // First bit of a freshly loaded word.
  function automatic logic head_bit(input logic [WIDTH-1:0] v);
    head_bit = LSB_FIRST ? v[0] : v[WIDTH-1];
  endfunction

  // Bit that moves to the output end after one shift.
  function automatic logic next_bit(input logic [WIDTH-1:0] v);
    next_bit = LSB_FIRST ? v[1] : v[WIDTH-2];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    shift_once = LSB_FIRST ? {1'b0, v[WIDTH-1:1]} : {v[WIDTH-2:0], 1'b0};
  endfunction

  // Ready depends only on registered state and reset, never on inValid.
  assign inReady  = !pREST && ((state_r == S_IDLE) || at_max_s);
  assign accept_s = inValid && inReady;
  assign inc_s    = (state_r == S_SHIFT) && !at_max_s;

  bit_counter_sync #(
    .N (WIDTH)
  ) u_bit_cnt (
    .clk       (pCLK),
    .clr       (pREST),
    .load_zero (accept_s),
    .inc       (inc_s),
    .count     (bit_cnt_s),
    .at_max    (at_max_s)
  );

  // Serializer FSM with shift register and registered W/wValid.
  always_ff @(posedge pCLK) begin
    if (pREST) begin
      state_r  <= S_IDLE;
      shreg_r  <= {WIDTH{1'b0}};
      w_r      <= IDLE_BIT;
      wvalid_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            state_r  <= S_SHIFT;
            shreg_r  <= inWord;
            w_r      <= head_bit(inWord);
            wvalid_r <= 1'b1;
          end else begin
            state_r  <= S_IDLE;
            shreg_r  <= shreg_r;
            w_r      <= IDLE_BIT;
            wvalid_r <= 1'b0;
          end
        end
        S_SHIFT: begin
          if (!at_max_s) begin
            state_r  <= S_SHIFT;
            shreg_r  <= shift_once(shreg_r);
            w_r      <= next_bit(shreg_r);
            wvalid_r <= 1'b1;
          end else if (accept_s) begin
            // Last bit on W and a new word offered: reload with no idle gap.
            state_r  <= S_SHIFT;
            shreg_r  <= inWord;
            w_r      <= head_bit(inWord);
            wvalid_r <= 1'b1;
          end else begin
            state_r  <= S_IDLE;
            shreg_r  <= shreg_r;
            w_r      <= IDLE_BIT;
            wvalid_r <= 1'b0;
          end
        end
        default: begin
          state_r  <= S_IDLE;
          shreg_r  <= {WIDTH{1'b0}};
          w_r      <= IDLE_BIT;
          wvalid_r <= 1'b0;
        end
      endcase
    end
  end

  assign W        = w_r;
  assign wValid   = wvalid_r;
  assign wordDone = (state_r == S_SHIFT) && at_max_s;
  assign busy     = (state_r == S_SHIFT);

endmodule
